// File: rtl/iso16_plugin_scheduler.sv
// Start/collect/accumulate sequencer for the ISO-16 plugin bank.
// Define ISO16_SCHED_TIMEOUT_EN to bound COLLECT by COLLECT_CYCLES and make timeout/missing_mask live.
module iso16_plugin_scheduler #(
   parameter int NUM_PLUGINS    = 4,
   parameter int WARP_WIDTH     = 16,
   parameter int ERROR_WIDTH    = 32,
   parameter int COLLECT_CYCLES = 8,
   parameter int SUM_WIDTH      = WARP_WIDTH + 3
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              cycle_req,
   input  logic [NUM_PLUGINS-1:0]            plugin_enable,
   output logic                              cycle_busy,
   output logic [NUM_PLUGINS-1:0]            plugin_start,
   input  logic [NUM_PLUGINS-1:0]            plugin_valid,
   input  logic [NUM_PLUGINS*WARP_WIDTH-1:0] plugin_warp_x_flat,
   input  logic [NUM_PLUGINS*WARP_WIDTH-1:0] plugin_warp_y_flat,
   input  logic [NUM_PLUGINS*WARP_WIDTH-1:0] plugin_warp_z_flat,
   input  logic [NUM_PLUGINS*ERROR_WIDTH-1:0] plugin_error_flat,
   output logic [SUM_WIDTH-1:0]              sum_warp_x,
   output logic [SUM_WIDTH-1:0]              sum_warp_y,
   output logic [SUM_WIDTH-1:0]              sum_warp_z,
   output logic [ERROR_WIDTH-1:0]            sum_error,
   output logic                              result_valid,
   output logic [NUM_PLUGINS-1:0]            missing_mask,
   output logic                              timeout
);
   localparam int IDX_W = $clog2(NUM_PLUGINS);
   localparam int EXT_W = SUM_WIDTH - WARP_WIDTH;

   typedef enum logic [2:0] {S_IDLE, S_START, S_COLLECT, S_ACCUM, S_DONE} state_t;

   state_t                 r_state, w_next;
   logic [NUM_PLUGINS-1:0] r_en, r_start, r_acc;
   logic [IDX_W-1:0]       r_idx;
   logic [SUM_WIDTH-1:0]   r_sx, r_sy, r_sz;
   logic [ERROR_WIDTH-1:0] r_err;

   logic                   w_all_valid, w_expire, w_last_idx;
   logic [WARP_WIDTH-1:0]  w_wx, w_wy, w_wz;
   logic [ERROR_WIDTH-1:0] w_err;
   logic [ERROR_WIDTH:0]   w_err_add;

   assign w_all_valid = ((plugin_valid & r_en) == r_en);
   assign w_last_idx  = (r_idx == IDX_W'(NUM_PLUGINS - 1));

   // Slot currently being accumulated, selected by the ACCUM index
   assign w_wx      = plugin_warp_x_flat[int'(r_idx)*WARP_WIDTH +: WARP_WIDTH];
   assign w_wy      = plugin_warp_y_flat[int'(r_idx)*WARP_WIDTH +: WARP_WIDTH];
   assign w_wz      = plugin_warp_z_flat[int'(r_idx)*WARP_WIDTH +: WARP_WIDTH];
   assign w_err     = plugin_error_flat[int'(r_idx)*ERROR_WIDTH +: ERROR_WIDTH];
   assign w_err_add = {1'b0, r_err} + {1'b0, w_err};

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (cycle_req) w_next = S_START;
         S_START:   w_next = S_COLLECT;
         S_COLLECT: if (w_all_valid || w_expire) w_next = S_ACCUM;
         S_ACCUM:   if (w_last_idx) w_next = S_DONE;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_en    <= '0;
         r_start <= '0;
         r_acc   <= '0;
         r_idx   <= '0;
         r_sx    <= '0;
         r_sy    <= '0;
         r_sz    <= '0;
         r_err   <= '0;
      end else begin
         r_state <= w_next;
         r_start <= '0;
         case (r_state)
            S_IDLE: if (cycle_req) begin
               r_en    <= plugin_enable;
               r_start <= plugin_enable;
               r_idx   <= '0;
               r_sx    <= '0;
               r_sy    <= '0;
               r_sz    <= '0;
               r_err   <= '0;
            end
            S_COLLECT: begin
               if (w_all_valid)   r_acc <= r_en;
               else if (w_expire) r_acc <= r_en & plugin_valid;
            end
            S_ACCUM: begin
               r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
               if (r_acc[r_idx]) begin
                  r_sx  <= r_sx + {{EXT_W{w_wx[WARP_WIDTH-1]}}, w_wx};
                  r_sy  <= r_sy + {{EXT_W{w_wy[WARP_WIDTH-1]}}, w_wy};
                  r_sz  <= r_sz + {{EXT_W{w_wz[WARP_WIDTH-1]}}, w_wz};
                  // carry out of the unsigned add means the total no longer fits: pin at all-ones
                  r_err <= w_err_add[ERROR_WIDTH] ? '1 : w_err_add[ERROR_WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ISO16_SCHED_TIMEOUT_EN
   localparam int CNT_W = (COLLECT_CYCLES > 1) ? $clog2(COLLECT_CYCLES) : 1;

   logic [CNT_W-1:0]       r_cnt;
   logic [NUM_PLUGINS-1:0] r_missing;
   logic                   r_timeout;

   assign w_expire = (r_cnt == CNT_W'(COLLECT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_missing <= '0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (cycle_req) begin
               r_missing <= '0;
               r_timeout <= 1'b0;
            end
            S_START: r_cnt <= '0;
            S_COLLECT: if (!w_all_valid) begin
               if (w_expire) begin
                  r_missing <= r_en & ~plugin_valid;
                  r_timeout <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign missing_mask = r_missing;
   assign timeout      = r_timeout;
`else
   assign w_expire     = 1'b0;
   assign missing_mask = '0;
   assign timeout      = 1'b0;
`endif

   assign cycle_busy   = (r_state != S_IDLE);
   assign result_valid = (r_state == S_DONE);
   assign plugin_start = r_start;
   assign sum_warp_x   = r_sx;
   assign sum_warp_y   = r_sy;
   assign sum_warp_z   = r_sz;
   assign sum_error    = r_err;
endmodule

// File: doc/iso16_plugin_scheduler.md
# iso16_plugin_scheduler

Sequencer for the ISO‑16 plugin bank. It sits between the top-level frame controller and up to NUM_PLUGINS plugin instances of the ALPHA/BETA/GAMMA/DELTA kind. On each cycle request it:
- starts the enabled plugins,
- runs the COLLECT window until every enabled plugin reports valid, or until the window expires,
- accumulates the warp vectors and error contributions serially,
- presents the totals with a one-cycle result strobe.

## Interface
- NUM_PLUGINS, 4, number of plugin slots (2..8)
- WARP_WIDTH, 16, per-plugin warp component width, two's complement
- ERROR_WIDTH, 32, per-plugin and summed error width, unsigned
- COLLECT_CYCLES, 8, maximum COLLECT window length in cycles (≥1)
- SUM_WIDTH, WARP_WIDTH+3, summed warp component width, signed

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cycle_req  in  1  request one collection round; accepted only in IDLE
- plugin_enable  in  NUM_PLUGINS  per-slot enable; sampled on acceptance
- cycle_busy  out  1  high in every state except IDLE
- plugin_start  out  NUM_PLUGINS  one-cycle start pulse to enabled slots
- plugin_valid  in  NUM_PLUGINS  per-slot valid (level, held by plugin)
- plugin_warp_x_flat / _y_flat / _z_flat  in  NUM_PLUGINS*WARP_WIDTH  slot i at bits [i*WARP_WIDTH +: WARP_WIDTH]
- plugin_error_flat  in  NUM_PLUGINS*ERROR_WIDTH  slot i at [i*ERROR_WIDTH +: ERROR_WIDTH]
- sum_warp_x / _y / _z  out  SUM_WIDTH  signed totals
- sum_error  out  ERROR_WIDTH  saturating total
- result_valid  out  1  one-cycle strobe; totals valid while high and held until next acceptance
- missing_mask  out  NUM_PLUGINS  enabled slots not valid at COLLECT exit
- timeout  out  1  COLLECT ended by window expiry

## Operation
- States: IDLE → START → COLLECT → ACCUM → DONE → IDLE.
- **IDLE:** when cycle_req=1:
  - latch plugin_enable into en_q;
  - clear sums, missing_mask and timeout;
  - go to START.
- **START:** one cycle. plugin_start = en_q (registered output, high exactly this cycle). Go to COLLECT; window counter = 0.
- **COLLECT:**
  - Each cycle, test (plugin_valid & en_q) == en_q. When true, latch acc_mask = en_q and go to ACCUM.
  - Otherwise the counter increments. When counter == COLLECT_CYCLES-1 without success:
    - latch acc_mask = en_q & plugin_valid;
    - missing_mask = en_q & ~plugin_valid;
    - timeout = 1;
    - go to ACCUM.
  - en_q = 0: the test passes on the first COLLECT cycle.
- **ACCUM:** exactly NUM_PLUGINS cycles, index i = 0..NUM_PLUGINS-1.
  - If acc_mask[i]: sum_warp_* += sign-extend(warp_*[i]) and sum_error = sat(sum_error + error[i]).
  - Skipped slots still consume their cycle.
  - Inputs are sampled in the slot's ACCUM cycle; plugins hold their outputs stable for the round.
- **DONE:** one cycle, result_valid = 1. Go to IDLE.
- Arithmetic rules:
  - Warp adds are two's complement at SUM_WIDTH and never overflow for NUM_PLUGINS ≤ 8.
  - Error add saturates at all-ones; it never wraps.
- cycle_req outside IDLE is ignored (not queued).
- Late plugin_valid after a timeout exit has no effect on the round.
- Reset, at any state, returns to IDLE on that edge. Reset values:
  - cycle_busy, plugin_start, result_valid, timeout = 0;
  - sums = 0; missing_mask = 0; en_q = 0;
  - counter and index = 0.

## Timing
- cycle_req sampled in cycle 0 → START in cycle 1 (plugin_start high) → COLLECT from cycle 2.
- Plugins that latch at the end of cycle 1 satisfy COLLECT in cycle 2 (minimum COLLECT length 1).
- ACCUM occupies cycles 3 .. 2+NUM_PLUGINS; DONE (result_valid) follows in cycle 3+NUM_PLUGINS, which is cycle 7 for the defaults.
- Worst case (timeout): result_valid in cycle 2+COLLECT_CYCLES+NUM_PLUGINS.
- cycle_busy is high from cycle 1 through the DONE cycle inclusive. The next request can be accepted in the cycle after DONE.

## Configuration
- ISO16_SCHED_TIMEOUT_EN defined:
  - COLLECT is bounded by COLLECT_CYCLES as above;
  - timeout and missing_mask are live.
- Not defined:
  - COLLECT waits indefinitely for all enabled slots;
  - timeout and missing_mask are tied to 0;
  - COLLECT_CYCLES is unused and no counter is synthesised.

## Test plan
- **All four enabled, every slot x=18, y=6, z=0xFFFD (−3), error=4; req at cycle 0**
  - plugin_start=4'b1111 in cycle 1;
  - result_valid in cycle 7;
  - sum_warp_x=72, sum_warp_y=24, sum_warp_z=−12 (19'h7FFF4), sum_error=16;
  - timeout=0.
- **plugin_enable=4'b0101, same data**
  - plugin_start=4'b0101 only;
  - sums x=36, y=12, z=−6, error=8;
  - result_valid in cycle 7.
- **ISO16_SCHED_TIMEOUT_EN on, slot 2 never valid**
  - result_valid in cycle 14;
  - timeout=1, missing_mask=4'b0100;
  - x=54, error=12.
- **Slot errors 0xFFFF_FFF0 and 0x20, others 0**
  - sum_error=0xFFFF_FFFF (saturated).
- **plugin_enable=0**
  - plugin_start stays 0; sums 0; result_valid in cycle 7.
- **rst asserted in cycle 4 (ACCUM); second cycle_req held high during busy**
  - after the reset edge: IDLE, all outputs at reset values;
  - the request raised during busy is not accepted until IDLE.
